knn_topk: RTL and testbench
===========================

KNN_TOPK -- requirements
Module: knn_topk

Interface
REQ-001 Parameter COORD_W, default 16, signed coordinate width.
REQ-002 Parameter NDIM, default 2, dimensions per point.
REQ-003 Parameter K, default 4, nearest neighbours kept; 1..16.
REQ-004 Parameter ID_W, default 8, data-point identifier width.
REQ-005 Derived DIST_W = 2*COORD_W + clog2(NDIM) + 1, unsigned squared-distance width.
REQ-006 clk  in  1  single clock; all logic rising-edge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 start  in  1  one-cycle pulse; latches test point, clears list.
REQ-009 test_pt  in  NDIM*COORD_W  test point, dim 0 in LSBs.
REQ-010 in_valid  in  1  data point offered.
REQ-011 in_ready  out  1  core accepts data point this cycle.
REQ-012 in_last  in  1  qualifies final data point of the set.
REQ-013 data_pt  in  NDIM*COORD_W  data point, same packing.
REQ-014 data_id  in  ID_W  identifier of data point.
REQ-015 out_valid  out  1  result lists valid; held until start or rst.
REQ-016 knn_id  out  K*ID_W  neighbour IDs, rank 0 (nearest) in LSBs.
REQ-017 knn_dist  out  K*DIST_W  matching squared distances.
REQ-018 knn_cnt  out  clog2(K+1)  number of valid entries, saturates at K.

Function
REQ-019 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE->RUN on start; DONE->RUN on start; start in RUN/DRAIN restarts (list cleared, in-flight points discarded).
REQ-021 in_ready = 1 only in RUN; a point transfers on in_valid & in_ready.
REQ-022 Transfer with in_last=1: RUN->DRAIN; DRAIN->DONE when pipeline empty.
REQ-023 Distance = sum over dims of (data-test)^2; differences COORD_W+1 bits signed, squares exact, sum exact in DIST_W; no saturation.
REQ-024 Pipeline: stage 1 registers squared differences, stage 2 registers sum, stage 3 inserts into list; accepted point affects list 3 cycles after transfer.
REQ-025 Insertion: list sorted ascending; new entry placed before first entry with strictly greater distance; lower ranks shift up one; entry at rank K-1 dropped when list full.
REQ-026 Ties: equal distance keeps earlier-arrived entry at lower rank.
REQ-027 New distance >= rank K-1 distance with full list: list unchanged.
REQ-028 One insertion per cycle; back-to-back transfers sustained at 1 point/cycle.
REQ-029 out_valid rises the cycle after DRAIN->DONE; deasserts on start.
REQ-030 Unused ranks (index >= knn_cnt) read ID 0, distance all-ones.
REQ-031 in_valid in IDLE/DRAIN/DONE ignored; in_last without transfer ignored.
REQ-032 Empty set impossible: in_last on first point yields knn_cnt=1.

Reset
REQ-033 rst forces IDLE, in_ready=0, out_valid=0, knn_cnt=0, all IDs 0, all distances all-ones, pipeline valids 0.
REQ-034 rst overrides start in the same cycle; rst mid-RUN discards all state.

Structure
REQ-035 Shared package knn_pkg holds FSM state encoding and DIST_W/clog2 helper functions.
REQ-036 Sub-module knn_sorted_list (parameters K, ID_W, DIST_W) implements REQ-025..027, REQ-030; knn_topk holds FSM and distance pipeline.

Verification
REQ-037 NDIM=2,K=4: test (0,0); points id1(3,4)=25, id2(1,1)=2, id3(0,2)=4, id4(5,0)=25, id5(10,10)=200, last on id5 -> ids 2,3,1,4, dists 2,4,25,25, knn_cnt=4.
REQ-038 Negative coords: test (-3,-3), point id7(3,3) -> dist 72; test (-32768,-32768), point (32767,32767) -> dist 2*65535^2=8589672450 exact.
REQ-039 Two points only, last on second (dists 9,1) -> ids ordered second,first, knn_cnt=2, ranks 2..3 ID 0 dist all-ones.
REQ-040 Streaming 100 random points with in_valid held high -> in_ready never drops in RUN; result matches stable-sort model.
REQ-041 start pulse mid-RUN after 5 points, then 3 new points -> result contains only new 3; rst mid-DRAIN -> out_valid=0, knn_cnt=0, IDLE.
REQ-042 Tie test: ids 10,11,12 all dist 8 with K=2 -> result ids 10,11.

Source files
------------

// File: rtl/knn_pkg.sv
// Shared definitions for the k-nearest-neighbour top-k core: FSM state
// encoding and width helpers used by the interface, the top and the list.
package knn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    // Width of an exact, unsigned squared Euclidean distance.
    function automatic int unsigned dist_w(input int unsigned coord_w, input int unsigned ndim);
        return 2 * coord_w + clog2(ndim) + 1;
    endfunction

endpackage

// File: rtl/knn_topk_if.sv
// Point-stream and result bus of the top-k core.
interface knn_topk_if
    import knn_pkg::*;
#(
    parameter int unsigned COORD_W = 16,
    parameter int unsigned NDIM    = 2,
    parameter int unsigned K       = 4,
    parameter int unsigned ID_W    = 8
);
    localparam int unsigned DIST_W = dist_w(COORD_W, NDIM);
    localparam int unsigned CNT_W  = clog2(K + 1);

    logic                      start;
    logic [NDIM*COORD_W-1:0]   test_pt;
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_last;
    logic [NDIM*COORD_W-1:0]   data_pt;
    logic [ID_W-1:0]           data_id;
    logic                      out_valid;
    logic [K*ID_W-1:0]         knn_id;
    logic [K*DIST_W-1:0]       knn_dist;
    logic [CNT_W-1:0]          knn_cnt;

    modport master (
        output start, test_pt, in_valid, in_last, data_pt, data_id,
        input  in_ready, out_valid, knn_id, knn_dist, knn_cnt
    );

    modport slave (
        input  start, test_pt, in_valid, in_last, data_pt, data_id,
        output in_ready, out_valid, knn_id, knn_dist, knn_cnt
    );

endinterface

// File: rtl/knn_sorted_list.sv
// Ascending sorted list of the K smallest distances seen since the last
// clear, with stable ordering on ties. Unused ranks hold ID 0 and an
// all-ones distance.
module knn_sorted_list
    import knn_pkg::*;
#(
    parameter int unsigned K      = 4,
    parameter int unsigned ID_W   = 8,
    parameter int unsigned DIST_W = 34,
    localparam int unsigned CNT_W = clog2(K + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  ins_valid,
    input  logic [ID_W-1:0]       ins_id,
    input  logic [DIST_W-1:0]     ins_dist,
    output logic [K*ID_W-1:0]     list_id,
    output logic [K*DIST_W-1:0]   list_dist,
    output logic [CNT_W-1:0]      list_cnt
);

    logic [ID_W-1:0]   id_q   [K];
    logic [DIST_W-1:0] dist_q [K];
    logic [CNT_W-1:0]  cnt_q;
    logic [ID_W-1:0]   id_d   [K];
    logic [DIST_W-1:0] dist_d [K];
    logic [CNT_W-1:0]  cnt_d;
    logic [K-1:0]      gt;

    // Insertion: gt is monotone (empty slots count as greater), so the first
    // set bit is the insertion point and every later set bit shifts up one.
    always_comb begin
        id_d   = id_q;
        dist_d = dist_q;
        cnt_d  = cnt_q;
        gt     = '0;
        for (int unsigned i = 0; i < K; i++) begin
            gt[i] = (i >= 32'(cnt_q)) || (dist_q[i] > ins_dist);
        end
        if (ins_valid) begin
            if (gt[0]) begin
                id_d[0]   = ins_id;
                dist_d[0] = ins_dist;
            end
            for (int unsigned i = 1; i < K; i++) begin
                if (gt[i] && !gt[i-1]) begin
                    id_d[i]   = ins_id;
                    dist_d[i] = ins_dist;
                end else if (gt[i]) begin
                    id_d[i]   = id_q[i-1];
                    dist_d[i] = dist_q[i-1];
                end
            end
            if (cnt_q != CNT_W'(K)) cnt_d = cnt_q + 1'b1;
        end
    end

    // List registers; reset and clear both empty the list.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int unsigned i = 0; i < K; i++) begin
                id_q[i]   <= '0;
                dist_q[i] <= '1;
            end
            cnt_q <= '0;
        end else begin
            id_q   <= id_d;
            dist_q <= dist_d;
            cnt_q  <= cnt_d;
        end
    end

    // Flatten ranks onto the output buses, rank 0 in the LSBs.
    always_comb begin
        list_id   = '0;
        list_dist = '0;
        for (int unsigned i = 0; i < K; i++) begin
            list_id[i*ID_W +: ID_W]       = id_q[i];
            list_dist[i*DIST_W +: DIST_W] = dist_q[i];
        end
        list_cnt = cnt_q;
    end

endmodule

// File: rtl/knn_topk.sv
// Top-k nearest-neighbour core: control FSM plus a two-stage squared
// distance pipeline feeding the sorted list (third stage).
module knn_topk
    import knn_pkg::*;
#(
    parameter int unsigned COORD_W = 16,
    parameter int unsigned NDIM    = 2,
    parameter int unsigned K       = 4,
    parameter int unsigned ID_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    knn_topk_if.slave   bus
);

    localparam int unsigned DIST_W = dist_w(COORD_W, NDIM);
    localparam int unsigned PT_W   = NDIM * COORD_W;

    state_t                   state, state_nx;
    logic                     xfer, accept;
    logic [PT_W-1:0]          test_q;
    logic signed [DIST_W-1:0] diff  [NDIM];
    logic [DIST_W-1:0]        sq    [NDIM];
    logic [DIST_W-1:0]        sum;
    logic                     s1_valid, s2_valid;
    logic [ID_W-1:0]          s1_id, s2_id;
    logic [DIST_W-1:0]        s1_sq [NDIM];
    logic [DIST_W-1:0]        s2_dist;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and handshake outputs; start restarts from any state.
    always_comb begin
        state_nx      = state;
        xfer          = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nx = RUN;
            RUN: begin
                bus.in_ready = 1'b1;
                xfer         = bus.in_valid;
                if (!bus.start && xfer && bus.in_last) state_nx = DRAIN;
            end
            DRAIN: begin
                if (bus.start)                   state_nx = RUN;
                else if (!s1_valid && !s2_valid) state_nx = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.start) state_nx = RUN;
            end
            default: state_nx = IDLE;
        endcase
        accept = xfer && !bus.start;
    end

    // Test point captured on start.
    always_ff @(posedge clk) begin
        if (rst)            test_q <= '0;
        else if (bus.start) test_q <= bus.test_pt;
    end

    // Per-dimension squared difference. Working at full distance width is
    // exact: each square is below 2^(2*COORD_W), far below the sign bit.
    always_comb begin
        diff = '{default: '0};
        sq   = '{default: '0};
        for (int unsigned d = 0; d < NDIM; d++) begin
            diff[d] = DIST_W'(signed'(bus.data_pt[d*COORD_W +: COORD_W]))
                    - DIST_W'(signed'(test_q[d*COORD_W +: COORD_W]));
            sq[d]   = diff[d] * diff[d];
        end
    end

    // Sum of the registered squares.
    always_comb begin
        sum = '0;
        for (int unsigned d = 0; d < NDIM; d++) sum = sum + s1_sq[d];
    end

    // Pipeline valids; start flushes in-flight points.
    always_ff @(posedge clk) begin
        if (rst || bus.start) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
        end
    end

    // Pipeline data; qualified by the valids above.
    always_ff @(posedge clk) begin
        s1_id   <= bus.data_id;
        s1_sq   <= sq;
        s2_id   <= s1_id;
        s2_dist <= sum;
    end

    knn_sorted_list #(
        .K      (K),
        .ID_W   (ID_W),
        .DIST_W (DIST_W)
    ) u_list (
        .clk       (clk),
        .rst       (rst),
        .clr       (bus.start),
        .ins_valid (s2_valid),
        .ins_id    (s2_id),
        .ins_dist  (s2_dist),
        .list_id   (bus.knn_id),
        .list_dist (bus.knn_dist),
        .list_cnt  (bus.knn_cnt)
    );

endmodule

// File: tb/tb_knn_topk.sv
// Self-checking bench for knn_topk: directed cases plus random streaming,
// checked against a selection-based stable top-k reference.
module tb_knn_topk;

    localparam int unsigned DW = 34;
    localparam logic [63:0] ONES = 64'h3_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;

    knn_topk_if #(.COORD_W(16), .NDIM(2), .K(4), .ID_W(8)) bus ();
    knn_topk_if #(.COORD_W(16), .NDIM(2), .K(2), .ID_W(8)) bus2 ();

    knn_topk #(.COORD_W(16), .NDIM(2), .K(4), .ID_W(8)) dut (
        .clk (clk), .rst (rst), .bus (bus.slave)
    );

    knn_topk #(.COORD_W(16), .NDIM(2), .K(2), .ID_W(8)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2.slave)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     tx, ty;
    longint md[$];
    int     mi[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int x, input int y);
        bus.start    = 1'b1;
        bus.test_pt  = {16'(y), 16'(x)};
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        tx = x;
        ty = y;
        md.delete();
        mi.delete();
        step();
        bus.start = 1'b0;
    endtask

    task automatic send(input int id, input int x, input int y, input bit last, input bit stream);
        int     w;
        longint dx, dy;
        bus.in_valid = 1'b1;
        bus.data_pt  = {16'(y), 16'(x)};
        bus.data_id  = 8'(id);
        bus.in_last  = last;
        if (stream) chk("stream_ready", 64'(bus.in_ready), 64'd1);
        w = 0;
        while (!bus.in_ready && w < 20) begin
            step();
            w++;
        end
        if (!bus.in_ready) begin
            chk("ready_timeout", 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b0;
            return;
        end
        step();
        dx = longint'(x) - longint'(tx);
        dy = longint'(y) - longint'(ty);
        md.push_back(dx * dx + dy * dy);
        mi.push_back(id);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int w;
        w = 0;
        while (!bus.out_valid && w < 30) begin
            step();
            w++;
        end
        chk({tag, "_done"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_latency"}, 64'(w), 64'd3);
    endtask

    // Reference: rank r is the smallest remaining distance, earliest arrival
    // winning ties; ranks beyond the point count are empty.
    task automatic check_result(input string tag);
        int          n, best;
        bit          taken[];
        logic [63:0] eid, ed, oid, od;
        n = md.size();
        taken = new[n];
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_cnt"}, 64'(bus.knn_cnt), 64'(n < 4 ? n : 4));
        for (int r = 0; r < 4; r++) begin
            if (r < n) begin
                best = -1;
                for (int j = 0; j < n; j++) begin
                    if (!taken[j] && (best < 0 || md[j] < md[best])) best = j;
                end
                taken[best] = 1'b1;
                eid = 64'(mi[best]);
                ed  = 64'(md[best]);
            end else begin
                eid = 64'd0;
                ed  = ONES;
            end
            oid = 64'(bus.knn_id[r*8 +: 8]);
            od  = 64'(bus.knn_dist[r*DW +: DW]);
            chk($sformatf("%s_id%0d", tag, r), oid, eid);
            chk($sformatf("%s_dist%0d", tag, r), od, ed);
        end
    endtask

    initial begin
        logic signed [15:0] r16x, r16y;
        int x, y, w;

        bus.start = 1'b0;  bus.test_pt = '0; bus.in_valid = 1'b0;
        bus.in_last = 1'b0; bus.data_pt = '0; bus.data_id = '0;
        bus2.start = 1'b0; bus2.test_pt = '0; bus2.in_valid = 1'b0;
        bus2.in_last = 1'b0; bus2.data_pt = '0; bus2.data_id = '0;

        // Reset state
        rst = 1'b1;
        step(); step(); step();
        chk("rst_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_cnt", 64'(bus.knn_cnt), 64'd0);
        chk("rst_ids", 64'(bus.knn_id), 64'd0);
        for (int r = 0; r < 4; r++) chk($sformatf("rst_dist%0d", r), 64'(bus.knn_dist[r*DW +: DW]), ONES);
        rst = 1'b0;

        // in_valid in IDLE is ignored
        bus.in_valid = 1'b1; bus.in_last = 1'b1; bus.data_pt = '0;
        step(); step();
        chk("idle_ready", 64'(bus.in_ready), 64'd0);
        idle();
        step(); step(); step(); step();
        chk("idle_cnt", 64'(bus.knn_cnt), 64'd0);
        chk("idle_valid", 64'(bus.out_valid), 64'd0);

        // Basic ordering with a tie
        do_start(0, 0);
        chk("run_valid_low", 64'(bus.out_valid), 64'd0);
        send(1, 3, 4, 1'b0, 1'b0);
        send(2, 1, 1, 1'b0, 1'b0);
        send(3, 0, 2, 1'b0, 1'b0);
        send(4, 5, 0, 1'b0, 1'b0);
        send(5, 10, 10, 1'b1, 1'b0);
        idle();
        wait_done("basic");
        check_result("basic");

        // Traffic in DONE is ignored
        bus.in_valid = 1'b1; bus.in_last = 1'b1; bus.data_pt = '0; bus.data_id = 8'd99;
        step();
        chk("done_ready", 64'(bus.in_ready), 64'd0);
        step(); step();
        idle();
        step(); step(); step();
        check_result("done_hold");

        // Negative coordinates and the extreme corner
        do_start(-3, -3);
        chk("restart_valid", 64'(bus.out_valid), 64'd0);
        send(7, 3, 3, 1'b1, 1'b0);
        idle();
        wait_done("neg");
        check_result("neg");
        chk("neg_72", 64'(bus.knn_dist[DW-1:0]), 64'd72);

        do_start(-32768, -32768);
        send(9, 32767, 32767, 1'b1, 1'b0);
        idle();
        wait_done("corner");
        check_result("corner");
        chk("corner_exact", 64'(bus.knn_dist[DW-1:0]), 64'd8589672450);

        // Two points only, last on second
        do_start(0, 0);
        send(20, 3, 0, 1'b0, 1'b0);
        send(21, 1, 0, 1'b1, 1'b0);
        idle();
        wait_done("two");
        check_result("two");

        // Random streaming, in_valid held high
        do_start(int'($urandom_range(10)) - 5, int'($urandom_range(10)) - 5);
        for (int i = 0; i < 100; i++) begin
            if (i < 60) begin
                x = int'($urandom_range(16)) - 8;
                y = int'($urandom_range(16)) - 8;
            end else begin
                r16x = 16'($urandom);
                r16y = 16'($urandom);
                x = int'(r16x);
                y = int'(r16y);
            end
            send(int'($urandom_range(255)), x, y, i == 99, 1'b1);
        end
        idle();
        wait_done("stream");
        check_result("stream");

        // Restart mid-RUN discards in-flight and earlier points
        do_start(0, 0);
        for (int i = 0; i < 5; i++) send(30 + i, i, 0, 1'b0, 1'b0);
        do_start(1, 1);
        send(40, 4, 1, 1'b0, 1'b0);
        send(41, 1, 2, 1'b0, 1'b0);
        send(42, 1, 1, 1'b1, 1'b0);
        idle();
        wait_done("restart");
        check_result("restart");

        // Reset mid-DRAIN
        do_start(0, 0);
        send(50, 1, 1, 1'b1, 1'b0);
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("drain_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("drain_rst_cnt", 64'(bus.knn_cnt), 64'd0);
        chk("drain_rst_ready", 64'(bus.in_ready), 64'd0);
        step(); step(); step(); step(); step();
        chk("drain_rst_valid_later", 64'(bus.out_valid), 64'd0);
        chk("drain_rst_cnt_later", 64'(bus.knn_cnt), 64'd0);
        chk("drain_rst_dist0", 64'(bus.knn_dist[DW-1:0]), ONES);

        // Reset wins over a simultaneous start
        rst = 1'b1; bus.start = 1'b1;
        step();
        rst = 1'b0; bus.start = 1'b0;
        chk("rst_over_start", 64'(bus.in_ready), 64'd0);

        // Three-way tie with K=2 keeps the two earliest
        bus2.start = 1'b1; bus2.test_pt = '0;
        step();
        bus2.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus2.in_valid = 1'b1;
            bus2.data_id  = 8'(10 + k);
            bus2.in_last  = (k == 2);
            case (k)
                0:       bus2.data_pt = {16'(2), 16'(2)};
                1:       bus2.data_pt = {16'(2), 16'(-2)};
                default: bus2.data_pt = {16'(-2), 16'(2)};
            endcase
            chk("tie_ready", 64'(bus2.in_ready), 64'd1);
            step();
        end
        bus2.in_valid = 1'b0; bus2.in_last = 1'b0;
        w = 0;
        while (!bus2.out_valid && w < 30) begin
            step();
            w++;
        end
        chk("tie_done", 64'(bus2.out_valid), 64'd1);
        chk("tie_cnt", 64'(bus2.knn_cnt), 64'd2);
        chk("tie_id0", 64'(bus2.knn_id[7:0]), 64'd10);
        chk("tie_id1", 64'(bus2.knn_id[15:8]), 64'd11);
        chk("tie_dist0", 64'(bus2.knn_dist[DW-1:0]), 64'd8);
        chk("tie_dist1", 64'(bus2.knn_dist[2*DW-1:DW]), 64'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
